// File: rtl/led_pkg.sv
// Shared types and default timing for the WS2812-style LED strand driver.
package led_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_e;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } color_t;

  localparam int DEF_NUM_LEDS     = 50;
  localparam int DEF_ADDR_WIDTH   = 6;
  localparam int DEF_BIT_CYCLES   = 125;
  localparam int DEF_T0H_CYCLES   = 40;
  localparam int DEF_T1H_CYCLES   = 80;
  localparam int DEF_LATCH_CYCLES = 28000;
  localparam int BITS_PER_LED     = 24;
endpackage

// File: rtl/ws2812_bit_encoder.sv
// One-bit waveform generator: a high pulse whose width encodes the bit,
// padded low to a fixed bit period; bit_done marks the last cycle.
module ws2812_bit_encoder #(
  parameter int BIT_CYCLES = 125,
  parameter int T0H_CYCLES = 40,
  parameter int T1H_CYCLES = 80
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_start,
  input  logic bit_value,
  output logic level,
  output logic bit_done
);
  localparam int CW = $clog2(BIT_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          act_q, act_d;
  logic          val_q, val_d;

  always_comb begin
    bit_done = act_q && (cnt_q == CW'(BIT_CYCLES - 1));
    level    = act_q &&
               (cnt_q < (val_q ? CW'(T1H_CYCLES) : CW'(T0H_CYCLES)));
    cnt_d = cnt_q + CW'(1);
    act_d = act_q;
    val_d = val_q;
    if (bit_start) begin
      cnt_d = '0;
      act_d = 1'b1;
      val_d = bit_value;
    end else if (bit_done || !act_q) begin
      cnt_d = '0;
      act_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      act_q <= 1'b0;
      val_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      act_q <= act_d;
      val_q <= val_d;
    end
  end
endmodule

// File: rtl/led_strand_driver.sv
// Frame sequencer: fetches GRB per LED ahead of time, shifts it out MSB
// first through the bit encoder, then holds the line low to latch.
module led_strand_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS          = DEF_NUM_LEDS,
  parameter int LED_ADDRESS_WIDTH = DEF_ADDR_WIDTH,
  parameter int BIT_CYCLES        = DEF_BIT_CYCLES,
  parameter int T0H_CYCLES        = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES        = DEF_T1H_CYCLES,
  parameter int LATCH_CYCLES      = DEF_LATCH_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  output logic [LED_ADDRESS_WIDTH:0] next_led_request,
  input  logic [7:0]                 green_in,
  input  logic [7:0]                 red_in,
  input  logic [7:0]                 blue_in,
  input  logic                       color_valid,
  output logic                       strand_out,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       underflow
);
  localparam int AW = LED_ADDRESS_WIDTH + 1;
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [AW-1:0] LAST = AW'(NUM_LEDS - 1);

  if (!(T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad
    $error("led_strand_driver: need T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end

  state_e        state_q, state_d;
  logic [AW-1:0] req_q, req_d;
  logic [AW-1:0] led_q, led_d;
  logic          pend_q, pend_d;
  color_t        pf_q, pf_d;
  logic          pf_full_q, pf_full_d;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic          wait_q, wait_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          uf_q, uf_d;
  logic          done_q, done_d;

  logic   bit_start, bit_value, bit_done, level;
  logic   avail, load;
  color_t in_c, nxt_c;

  assign in_c  = {green_in, red_in, blue_in};
  // A colour arriving on the very cycle it is needed bypasses the prefetch reg
  assign avail = pf_full_q | (pend_q & color_valid);
  assign nxt_c = pf_full_q ? pf_q : in_c;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    led_d     = led_q;
    pend_d    = pend_q;
    pf_d      = pf_q;
    pf_full_d = pf_full_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wait_d    = wait_q;
    lat_d     = lat_q;
    uf_d      = uf_q;
    done_d    = 1'b0;
    load      = 1'b0;
    bit_start = 1'b0;
    bit_value = 1'b0;

    if (pend_q && color_valid) begin
      pf_d      = in_c;
      pf_full_d = 1'b1;
      pend_d    = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (go && !done_q) begin
          state_d = FETCH;
          req_d   = '0;
          pend_d  = 1'b1;
        end
      end
      FETCH: load = avail;
      SEND: begin
        if (wait_q) begin
          load = avail;
        end else if (bit_done) begin
          if (bit_cnt_q != 5'd0) begin
            bit_start = 1'b1;
            bit_value = shift_q[22];
            shift_d   = {shift_q[22:0], 1'b0};
            bit_cnt_d = bit_cnt_q - 5'd1;
          end else if (led_q == LAST) begin
            state_d = LATCH;
            lat_d   = '0;
          end else if (avail) begin
            load = 1'b1;
          end else begin
            wait_d = 1'b1;
            uf_d   = 1'b1;
          end
        end
      end
      LATCH: begin
        if (lat_q == LW'(LATCH_CYCLES - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
    endcase

    if (load) begin
      state_d   = SEND;
      bit_start = 1'b1;
      bit_value = nxt_c.g[7];
      shift_d   = nxt_c;
      bit_cnt_d = 5'(BITS_PER_LED - 1);
      led_d     = req_q;
      wait_d    = 1'b0;
      pf_full_d = 1'b0;
      pend_d    = 1'b0;
      if (req_q < LAST) begin
        req_d  = req_q + AW'(1);
        pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= '0;
      led_q     <= '0;
      pend_q    <= 1'b0;
      pf_q      <= '0;
      pf_full_q <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wait_q    <= 1'b0;
      lat_q     <= '0;
      uf_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      led_q     <= led_d;
      pend_q    <= pend_d;
      pf_q      <= pf_d;
      pf_full_q <= pf_full_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wait_q    <= wait_d;
      lat_q     <= lat_d;
      uf_q      <= uf_d;
      done_q    <= done_d;
    end
  end

  ws2812_bit_encoder #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_enc (
    .clk       (clk),
    .rst       (rst),
    .bit_start (bit_start),
    .bit_value (bit_value),
    .level     (level),
    .bit_done  (bit_done)
  );

  assign strand_out       = level;
  assign busy             = (state_q != IDLE);
  assign frame_done       = done_q;
  assign underflow        = uf_q;
  assign next_led_request = req_q;
endmodule

// File: tb/tb_led_strand_driver.sv
// Bench for led_strand_driver: upstream colour model, waveform decoder
// and frame-level timing reference.
module tb_led_strand_driver;
  localparam int NL  = 2;
  localparam int BIT = 12;
  localparam int T0H = 4;
  localparam int T1H = 8;
  localparam int LAT = 50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       go = 1'b0;
  logic [6:0] next_led_request;
  logic [7:0] green_in, red_in, blue_in;
  logic       color_valid;
  logic       strand_out, busy, frame_done, underflow;

  led_strand_driver #(
    .NUM_LEDS          (NL),
    .LED_ADDRESS_WIDTH (6),
    .BIT_CYCLES        (BIT),
    .T0H_CYCLES        (T0H),
    .T1H_CYCLES        (T1H),
    .LATCH_CYCLES      (LAT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .go               (go),
    .next_led_request (next_led_request),
    .green_in         (green_in),
    .red_in           (red_in),
    .blue_in          (blue_in),
    .color_valid      (color_valid),
    .strand_out       (strand_out),
    .busy             (busy),
    .frame_done       (frame_done),
    .underflow        (underflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Upstream colour source: answers each new request once after lat[] cycles
  logic [23:0] col [NL];
  int          lat [NL];
  int          vcyc [NL];
  bit          spur = 0;

  initial begin
    int  idx;
    int  wcnt;
    bit [NL-1:0] served;
    color_valid = 1'b0;
    {green_in, red_in, blue_in} = '0;
    served = '0;
    wcnt = 0;
    forever begin
      @(negedge clk);
      color_valid = 1'b0;
      {green_in, red_in, blue_in} = 24'($urandom);
      if (rst || !busy) begin
        served = '0;
        wcnt = 0;
      end else begin
        idx = int'(next_led_request);
        if (idx < NL && !served[idx]) begin
          if (wcnt >= lat[idx]) begin
            color_valid = 1'b1;
            {green_in, red_in, blue_in} = col[idx];
            served[idx] = 1'b1;
            vcyc[idx] = cyc;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else if (spur && $urandom_range(3, 0) == 0) begin
          color_valid = 1'b1;
        end
      end
    end
  end

  typedef struct {
    logic [23:0] c0;
    logic [23:0] c1;
    int          l0;
    int          l1;
    bit          uf;
    bit          spur;
    bit          go_mid;
  } vec_t;

  int last_w [NL*24];

  task automatic wait_done(input string nm);
    int n = 0;
    while (!frame_done && n < 4000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({nm, "_drain"}, frame_done, 1);
    @(negedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int       cy[$];
    logic     st[$];
    logic     bz[$];
    int       rq[$];
    int       starts[$];
    int       widths[$];
    int       n, w, bad, maxrq, s0, last;
    bit       fin;
    bit       late;
    logic [47:0] got, expb;
    col[0] = v.c0;
    col[1] = v.c1;
    lat[0] = v.l0;
    lat[1] = v.l1;
    spur   = v.spur;
    late   = (v.l1 > 300);
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    fin = 0;
    while (!fin && n < 4000) begin
      #1;
      cy.push_back(cyc);
      st.push_back(strand_out);
      bz.push_back(busy);
      rq.push_back(int'(next_led_request));
      if (frame_done) begin
        fin = 1;
      end else begin
        if (v.go_mid) go = (n == 100);
        @(negedge clk);
        n++;
      end
    end
    check({nm, "_finished"}, fin, 1);
    check({nm, "_busy_at_go"}, bz[0], 1);
    check({nm, "_req0_at_go"}, rq[0], 0);
    for (int i = 0; i < st.size(); i++) begin
      if (st[i] && (i == 0 || !st[i-1])) begin
        w = 0;
        for (int j = i; j < st.size() && st[j]; j++) w++;
        starts.push_back(i);
        widths.push_back(w);
      end
    end
    maxrq = 0;
    foreach (rq[i]) if (rq[i] > maxrq) maxrq = rq[i];
    check({nm, "_max_req"}, maxrq, NL - 1);
    check({nm, "_pulses"}, starts.size(), NL * 24);
    if (fin && starts.size() == NL * 24) begin
      bad = 0;
      for (int k = 0; k < NL * 24; k++) begin
        last_w[k] = widths[k];
        if (widths[k] != T0H && widths[k] != T1H) bad++;
        got[47-k] = (widths[k] == T1H);
      end
      expb = {v.c0, v.c1};
      check({nm, "_width_set"}, bad, 0);
      check({nm, "_grb"}, got, expb);
      bad = 0;
      for (int k = 1; k < NL * 24; k++) begin
        if (k == 24 && late) begin
          if (starts[k] - starts[k-1] <= BIT) bad++;
        end else if (starts[k] - starts[k-1] != BIT) begin
          bad++;
        end
      end
      check({nm, "_spacing"}, bad, 0);
      s0 = starts[0];
      check({nm, "_first_bit"}, cy[s0], vcyc[0] + 1);
      if (s0 > 0)
        check({nm, "_req_step"}, {rq[s0-1], rq[s0]}, {32'd0, 32'd1});
      else
        check({nm, "_req_step"}, s0, 1);
      if (late) check({nm, "_resume"}, cy[starts[24]], vcyc[1] + 1);
      last = st.size() - 1;
      check({nm, "_latch_len"}, cy[last] - cy[starts[NL*24-1]], BIT + LAT);
      check({nm, "_busy_fall"}, {bz[last-1], bz[last]}, 2'b10);
    end
    check({nm, "_underflow"}, underflow, v.uf);
    if (v.go_mid) go = 1'b1;
    @(negedge clk);
    #1;
    check({nm, "_done_pulse"}, frame_done, 0);
    check({nm, "_idle_after"}, busy, 0);
    if (v.go_mid) begin
      @(negedge clk);
      go = 1'b0;
      #1;
      check({nm, "_restart_busy"}, busy, 1);
      check({nm, "_restart_req"}, next_led_request, 0);
      wait_done(nm);
    end
  endtask

  initial begin
    vec_t tbl [4];
    vec_t rv;
    int   exp_w [24];
    int   n, mism;
    bit   hit;
    exp_w = '{8, 8, 8, 8, 8, 8, 8, 8, 4, 4, 4, 4, 4, 4, 4, 4,
              8, 4, 8, 4, 4, 8, 4, 8};
    tbl[0] = '{c0: 24'hFF00A5, c1: 24'h00FF01, l0: 2, l1: 2,
               uf: 0, spur: 0, go_mid: 0};
    tbl[1] = '{c0: 24'h123456, c1: 24'h00FF01, l0: 0, l1: 5,
               uf: 0, spur: 1, go_mid: 0};
    tbl[2] = '{c0: 24'h0F0F0F, c1: 24'hF0F0F0, l0: 3, l1: 3,
               uf: 0, spur: 0, go_mid: 1};
    tbl[3] = '{c0: 24'h00FF00, c1: 24'hA5A5A5, l0: 1, l1: 320,
               uf: 1, spur: 0, go_mid: 0};

    repeat (4) @(negedge clk);
    #1;
    check("rst_strand", strand_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_underflow", underflow, 0);
    check("rst_req", next_led_request, 0);
    rst = 1'b0;

    for (int t = 0; t < 4; t++) begin
      run_frame(tbl[t], $sformatf("vec%0d", t));
      if (t == 0) begin
        mism = 0;
        for (int k = 0; k < 24; k++) if (last_w[k] != exp_w[k]) mism++;
        check("vec0_led0_widths", mism, 0);
      end
    end

    col[0] = 24'hC3C3C3;
    col[1] = 24'hFFFFFF;
    lat[0] = 1;
    lat[1] = 320;
    spur = 0;
    vcyc[1] = 32'h7fff_ffff;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    n = 0;
    hit = 0;
    while (!hit && n < 2000) begin
      #1;
      if (strand_out && busy && underflow && next_led_request == 7'd1 &&
          cyc > vcyc[1]) begin
        hit = 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    check("midrst_reached", hit, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_strand", strand_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_underflow", underflow, 0);
    check("midrst_req", next_led_request, 0);
    check("midrst_done", frame_done, 0);
    rst = 1'b0;

    for (int f = 0; f < 10; f++) begin
      rv.c0 = 24'($urandom);
      rv.c1 = 24'($urandom);
      rv.l0 = $urandom_range(20, 0);
      rv.l1 = $urandom_range(250, 0);
      rv.uf = 0;
      rv.spur = 1'($urandom);
      rv.go_mid = 0;
      run_frame(rv, $sformatf("rand%0d", f));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
